// File: rtl/inv_stim_sequencer.sv
// Square-wave stimulus sequencer for the 3.3 V inverter: toggles stim, checks synchronised
// readback per edge, reports error count and settle latency. Optional stuck flag: INVSEQ_STUCK_EN.
`timescale 1ns/1ps

module inv_stim_sequencer #(
    parameter int unsigned CNT_W = 8,
    parameter int unsigned NUM_W = 8,
    parameter int unsigned ERR_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [CNT_W-1:0] settle_cycles,
    input  logic [NUM_W-1:0] num_toggles,
    input  logic             inv_out_raw,
    output logic             stim,
    output logic             busy,
    output logic             done,
    output logic             pass,
    output logic [ERR_W-1:0] err_count,
    output logic [CNT_W-1:0] last_latency,
    output logic [CNT_W-1:0] max_latency
`ifdef INVSEQ_STUCK_EN
    ,
    output logic             stuck
`endif
);

    typedef enum logic [1:0] {StIdle, StSettle, StCheck, StDone} state_e;

    state_e           state_q, state_d;
    logic             sync1_q, rsync_q;
    logic             stim_q, stim_d;
    logic             busy_q, busy_d;
    logic             pass_q, pass_d;
    logic             matched_q, matched_d;
    logic [CNT_W-1:0] settle_eff_q, settle_eff_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [NUM_W-1:0] rem_q, rem_d;
    logic [ERR_W-1:0] err_q, err_d;
    logic [CNT_W-1:0] last_q, last_d;
    logic [CNT_W-1:0] max_q, max_d;
    logic [CNT_W-1:0] lat_res;

    always_comb begin
        state_d      = state_q;
        stim_d       = stim_q;
        busy_d       = busy_q;
        pass_d       = pass_q;
        matched_d    = matched_q;
        settle_eff_d = settle_eff_q;
        cnt_d        = cnt_q;
        rem_d        = rem_q;
        err_d        = err_q;
        last_d       = last_q;
        max_d        = max_q;
        // All-ones latency marks an edge whose readback never matched.
        lat_res      = matched_q ? last_q : '1;

        unique case (state_q)
            StIdle: begin
                if (start) begin
                    settle_eff_d = (settle_cycles == '0) ? CNT_W'(1) : settle_cycles;
                    rem_d        = num_toggles;
                    err_d        = '0;
                    busy_d       = 1'b1;
                    if (num_toggles == '0) begin
                        state_d = StDone;
                    end else begin
                        stim_d    = ~stim_q;
                        cnt_d     = '0;
                        last_d    = '0;
                        max_d     = '0;
                        matched_d = 1'b0;
                        state_d   = StSettle;
                    end
                end
            end
            StSettle: begin
                cnt_d = cnt_q + CNT_W'(1);
                if ((rsync_q != stim_q) && !matched_q) begin
                    last_d    = cnt_q;
                    matched_d = 1'b1;
                end
                if (cnt_q == settle_eff_q - CNT_W'(1)) begin
                    state_d = StCheck;
                end
            end
            StCheck: begin
                last_d = lat_res;
                if (lat_res > max_q) begin
                    max_d = lat_res;
                end
                if ((rsync_q == stim_q) && (err_q != '1)) begin
                    err_d = err_q + ERR_W'(1);
                end
                rem_d = rem_q - NUM_W'(1);
                if (rem_q == NUM_W'(1)) begin
                    state_d = StDone;
                end else begin
                    stim_d    = ~stim_q;
                    cnt_d     = '0;
                    matched_d = 1'b0;
                    state_d   = StSettle;
                end
            end
            StDone: begin
                pass_d  = (err_q == '0);
                busy_d  = 1'b0;
                state_d = StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= StIdle;
            sync1_q      <= 1'b0;
            rsync_q      <= 1'b0;
            stim_q       <= 1'b0;
            busy_q       <= 1'b0;
            pass_q       <= 1'b0;
            matched_q    <= 1'b0;
            settle_eff_q <= '0;
            cnt_q        <= '0;
            rem_q        <= '0;
            err_q        <= '0;
            last_q       <= '0;
            max_q        <= '0;
        end else begin
            state_q      <= state_d;
            sync1_q      <= inv_out_raw;
            rsync_q      <= sync1_q;
            stim_q       <= stim_d;
            busy_q       <= busy_d;
            pass_q       <= pass_d;
            matched_q    <= matched_d;
            settle_eff_q <= settle_eff_d;
            cnt_q        <= cnt_d;
            rem_q        <= rem_d;
            err_q        <= err_d;
            last_q       <= last_d;
            max_q        <= max_d;
        end
    end

`ifdef INVSEQ_STUCK_EN
    // Flags a run whose readback never moved from its value at start.
    logic changed_q, changed_d, rs0_q, rs0_d, armed_q, armed_d, stuck_q, stuck_d;

    always_comb begin
        changed_d = changed_q;
        rs0_d     = rs0_q;
        armed_d   = armed_q;
        stuck_d   = stuck_q;
        unique case (state_q)
            StIdle: begin
                if (start) begin
                    changed_d = 1'b0;
                    rs0_d     = rsync_q;
                    armed_d   = (num_toggles != '0);
                    stuck_d   = 1'b0;
                end
            end
            StSettle, StCheck: begin
                if (rsync_q != rs0_q) begin
                    changed_d = 1'b1;
                end
            end
            StDone:  stuck_d = armed_q && !changed_q;
            default: ;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            changed_q <= 1'b0;
            rs0_q     <= 1'b0;
            armed_q   <= 1'b0;
            stuck_q   <= 1'b0;
        end else begin
            changed_q <= changed_d;
            rs0_q     <= rs0_d;
            armed_q   <= armed_d;
            stuck_q   <= stuck_d;
        end
    end

    assign stuck = stuck_q;
`endif

    assign stim         = stim_q;
    assign busy         = busy_q;
    assign done         = (state_q == StDone);
    assign pass         = pass_q;
    assign err_count    = err_q;
    assign last_latency = last_q;
    assign max_latency  = max_q;

endmodule

// File: doc/inv_stim_sequencer.md
Name: inv_stim_sequencer

Overview:
Digital sequencer that exercises the 3.3 V inverter under test. It drives a square-wave stimulus toward the inverter input through a digital pad and samples the inverter's level-shifted readback on a digital input pad. After every stimulus edge it checks that the readback settled to the inverted level within a programmed window. It accumulates an error count and a settle latency for each edge, and reports pass or fail when the run completes. It sits in the digital wrapper between the config pins and the pad driving the analog inverter.

Parameters:
CNT_W, 8, width of settle window and latency counters
NUM_W, 8, width of toggle-count field
ERR_W, 8, width of error counter

Ports:
clk  in  1  single clock
rst  in  1  asynchronous, active-high reset
start  in  1  one-cycle run request; ignored unless idle
settle_cycles  in  CNT_W  settle window per edge; 0 is treated as 1
num_toggles  in  NUM_W  stimulus edges per run
inv_out_raw  in  1  asynchronous inverter readback
stim  out  1  registered stimulus to inverter input
busy  out  1  high from the start-accept edge until DONE exits
done  out  1  one-cycle pulse at end of run
pass  out  1  err_count==0 at end of run; held until next run
err_count  out  ERR_W  edges that failed CHECK; saturating
last_latency  out  CNT_W  settle latency of most recent edge
max_latency  out  CNT_W  maximum latency over the run

Behaviour:
- Reset (asynchronous, any state): state=IDLE. stim, busy, done, pass, err_count, last_latency, max_latency are all 0. Both synchronizer flops are 0.
- inv_out_raw passes through a 2-flop synchronizer; its output is rsync. An ideal inverter therefore shows latency 2.
- States: IDLE, SETTLE, CHECK, DONE.
- IDLE, start=1:
  - Latch settle_eff = max(settle_cycles, 1), and latch num_toggles into rem.
  - If rem==0: go to DONE with err_count=0.
  - Otherwise: stim<=~stim, cnt<=0, err_count, last_latency and max_latency cleared, matched<=0, busy<=1, go to SETTLE.
- SETTLE:
  - Each cycle, cnt increments.
  - In the first cycle where rsync==~stim and matched==0: last_latency<=cnt, matched<=1.
  - In the cycle where cnt==settle_eff-1: go to CHECK. SETTLE therefore lasts exactly settle_eff cycles.
- CHECK (one cycle):
  - If matched==0, last_latency<=all-ones.
  - max_latency<=max(max_latency, resulting last_latency).
  - If rsync!=~stim: err_count increments, saturating at all-ones.
  - rem decrements.
  - If rem==0: go to DONE.
  - Otherwise: stim<=~stim, cnt<=0, matched<=0, go to SETTLE.
- Each edge costs settle_eff+1 cycles.
- DONE (one cycle): done=1, pass<=(err_count==0), busy<=0, go to IDLE.
- pass, err_count and both latency outputs hold their values until the next accepted start.
- stim keeps its last level between runs; it is never forced back to 0 except by rst.
- start while busy, or during DONE, is ignored with no side effect.
- A latency equal to all-ones means "no match observed".
- num_toggles is sampled only at start; later changes have no effect on the current run.
- rst mid-run aborts immediately to reset values; no done pulse is produced.

Optional Feature:
INVSEQ_STUCK_EN:
- Defined: adds output port stuck (1 bit, reset 0). During a run the block tracks whether rsync ever changed value. At DONE, stuck<=1 if rsync never changed and rem had been >0. stuck clears on the next accepted start.
- Undefined: the stuck port and its logic are absent; all other behaviour is identical.

Test Plan:
- Ideal inverter model (inv_out_raw = ~stim, zero delay), settle_cycles=4, num_toggles=4, start pulsed → busy rises at the accept edge; stim toggles 4 times, 5 cycles apart; done pulses in the 21st cycle after accept; pass=1, err_count=0, last_latency=2, max_latency=2, stim ends at 0.
- Ideal model, settle_cycles=1, num_toggles=3 → every CHECK fails; err_count=3, pass=0, last_latency=all-ones (0xFF).
- inv_out_raw tied 0, settle_cycles=4, num_toggles=4 → the rising edges match (latency 0) and the falling edges fail; err_count=2, pass=0. With INVSEQ_STUCK_EN defined, stuck=1.
- Inverter model with 3 extra cycles of delay, settle_cycles=8, num_toggles=2 → pass=1, last_latency=5, max_latency=5.
- num_toggles=0 with start → no stim change; done pulses in the cycle after accept; pass=1. Separately: start re-pulsed mid-run is ignored, and rst asserted mid-SETTLE returns all outputs to 0 with no done pulse.
